// File: rtl/rsa_pkg.sv
// ============================================================================
// Module  : rsa_pkg
// Brief   : Shared types and constants for the RSA modular-exponentiation core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

    localparam int c_DEF_WIDTH     = 8;
    localparam int c_DEF_EXP_WIDTH = 8;
    // Multiplying by plain 1 strips one factor of R, leaving the Montgomery domain
    localparam int c_MM_ONE        = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SQR    = 3'd1,
        S_SQR_W  = 3'd2,
        S_MUL    = 3'd3,
        S_MUL_W  = 3'd4,
        S_CONV   = 3'd5,
        S_CONV_W = 3'd6,
        S_DONE   = 3'd7
    } modexp_state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
// ============================================================================
// Module  : rsa_modexp_ctrl
// Brief   : Left-to-right binary modular exponentiation sequencer driving an
//           external Montgomery multiplier over a start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int EXP_WIDTH = c_DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic [WIDTH-1:0]     m_mont,
    input  logic [WIDTH-1:0]     r_mod_n,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    input  logic                 mm_done,
    input  logic [WIDTH-1:0]     mm_p
);

    localparam int                 c_CNT_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(c_MM_ONE);

    modexp_state_t          r_state,   w_state_nxt;
    logic [WIDTH-1:0]       r_acc,     w_acc_nxt;
    logic [WIDTH-1:0]       r_base,    w_base_nxt;
    logic [EXP_WIDTH-1:0]   r_exp,     w_exp_nxt;
    logic [c_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [WIDTH-1:0]       r_result,  w_result_nxt;
    logic                   w_exp_bit;
    logic                   w_last_bit;

    assign w_exp_bit  = r_exp[r_bit_cnt];
    assign w_last_bit = (r_bit_cnt == '0);
    assign result     = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_base    <= '0;
            r_exp     <= '0;
            r_bit_cnt <= '0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_base    <= w_base_nxt;
            r_exp     <= w_exp_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_result  <= w_result_nxt;
        end
    end

    // Operands are decoded from the state so they stay put across each *_W wait
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_base_nxt    = r_base;
        w_exp_nxt     = r_exp;
        w_bit_cnt_nxt = r_bit_cnt;
        w_result_nxt  = r_result;
        busy          = 1'b0;
        done          = 1'b0;
        mm_start      = 1'b0;
        mm_a          = '0;
        mm_b          = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt     = r_mod_n;
                    w_base_nxt    = m_mont;
                    w_exp_nxt     = exp_in;
                    w_bit_cnt_nxt = c_CNT_TOP;
                    w_state_nxt   = S_SQR;
                end
            end
            S_SQR: begin
                busy        = 1'b1;
                mm_start    = 1'b1;
                mm_a        = r_acc;
                mm_b        = r_acc;
                w_state_nxt = S_SQR_W;
            end
            S_SQR_W: begin
                busy = 1'b1;
                mm_a = r_acc;
                mm_b = r_acc;
                if (mm_done) begin
                    w_acc_nxt = mm_p;
                    if (w_exp_bit) begin
                        w_state_nxt = S_MUL;
                    end else if (w_last_bit) begin
                        w_state_nxt = S_CONV;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                        w_state_nxt   = S_SQR;
                    end
                end
            end
            S_MUL: begin
                busy        = 1'b1;
                mm_start    = 1'b1;
                mm_a        = r_acc;
                mm_b        = r_base;
                w_state_nxt = S_MUL_W;
            end
            S_MUL_W: begin
                busy = 1'b1;
                mm_a = r_acc;
                mm_b = r_base;
                if (mm_done) begin
                    w_acc_nxt = mm_p;
                    if (w_last_bit) begin
                        w_state_nxt = S_CONV;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                        w_state_nxt   = S_SQR;
                    end
                end
            end
            S_CONV: begin
                busy        = 1'b1;
                mm_start    = 1'b1;
                mm_a        = r_acc;
                mm_b        = c_ONE;
                w_state_nxt = S_CONV_W;
            end
            S_CONV_W: begin
                busy = 1'b1;
                mm_a = r_acc;
                mm_b = c_ONE;
                if (mm_done) begin
                    w_result_nxt = mm_p;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
// ============================================================================
// Module  : tb_rsa_modexp_ctrl
// Brief   : Directed bench for rsa_modexp_ctrl with N=143, R=256, M=7.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_modexp_ctrl;

    localparam int c_N = 143;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] exp_in = '0;
    logic [7:0] m_mont = 8'd76;
    logic [7:0] r_mod_n = 8'd113;
    logic       busy, done, mm_start, mm_done;
    logic [7:0] result, mm_a, mm_b, mm_p;

    logic       model_done = 1'b0;
    logic [7:0] model_p = '0;
    logic       inj_done = 1'b0;
    logic [7:0] inj_p = '0;

    assign mm_done = model_done | inj_done;
    assign mm_p    = inj_done ? inj_p : model_p;

    rsa_modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_in(exp_in),
        .m_mont(m_mont), .r_mod_n(r_mod_n), .busy(busy), .done(done),
        .result(result), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
        .mm_done(mm_done), .mm_p(mm_p)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural Montgomery multiplier: P = A*B*R^-1 mod N
    int unsigned rinv = 0;
    logic       pend = 1'b0;
    logic       pend_abort = 1'b0;
    logic       prev_start = 1'b0;
    logic [7:0] cap_a = '0, cap_b = '0;
    int         lat_cnt = 0;
    int         start_cnt = 0;
    int         stab_err = 0;
    int         overlap_err = 0;
    bit         lat_rand = 1'b0;

    function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b);
        int unsigned ua, ub, t;
        ua = a;
        ub = b;
        t  = (ua * ub) % c_N;
        t  = (t * rinv) % c_N;
        return t[7:0];
    endfunction

    always @(posedge clk) begin
        model_done <= 1'b0;
        prev_start <= mm_start;
        if (mm_start && prev_start) overlap_err <= overlap_err + 1;
        if (mm_start) start_cnt <= start_cnt + 1;
        if (pend) begin
            if (rst) pend_abort <= 1'b1;
            if (!pend_abort && !rst) begin
                if (mm_start) overlap_err <= overlap_err + 1;
                if (mm_a !== cap_a || mm_b !== cap_b) stab_err <= stab_err + 1;
            end
            if (lat_cnt <= 1) begin
                model_done <= 1'b1;
                model_p    <= mont(cap_a, cap_b);
                pend       <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end else if (mm_start) begin
            pend       <= 1'b1;
            pend_abort <= 1'b0;
            cap_a      <= mm_a;
            cap_b      <= mm_b;
            lat_cnt    <= lat_rand ? int'($urandom_range(1, 10)) : 3;
        end
    end

    // Results of the most recent do_run
    logic [7:0] run_res;
    int         run_starts;
    bit         run_ok;
    logic       run_busy1;
    logic       run_done2;

    task automatic do_run(input logic [7:0] e);
        int s0;
        int i;
        exp_in  = e;
        m_mont  = 8'd76;
        r_mod_n = 8'd113;
        @(negedge clk);
        start = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        start = 1'b0;
        run_busy1 = busy;
        i = 0;
        while (!done && i < 3000) begin
            @(negedge clk);
            i++;
        end
        run_ok     = done;
        run_res    = result;
        run_starts = start_cnt - s0;
        @(negedge clk);
        run_done2 = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++; if (mm_start !== 1'b0) $display("FAIL reset_mm_start: got %b expected 0", mm_start); else n_pass++;
        n_total++; if (result !== 8'd0) $display("FAIL reset_result: got %0d expected 0", result); else n_pass++;
        n_total++; if (mm_a !== 8'd0) $display("FAIL reset_mm_a: got %0d expected 0", mm_a); else n_pass++;
        n_total++; if (mm_b !== 8'd0) $display("FAIL reset_mm_b: got %0d expected 0", mm_b); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_e5();
        do_run(8'd5);
        n_total++; if (run_ok !== 1'b1) $display("FAIL e5_timeout: got done=%b expected 1", run_ok); else n_pass++;
        n_total++; if (run_res !== 8'd76) $display("FAIL e5_result: got %0d expected 76", run_res); else n_pass++;
        n_total++; if (run_starts !== 11) $display("FAIL e5_starts: got %0d expected 11", run_starts); else n_pass++;
        n_total++; if (run_busy1 !== 1'b1) $display("FAIL e5_busy: got %b expected 1", run_busy1); else n_pass++;
        n_total++; if (run_done2 !== 1'b0) $display("FAIL e5_done_pulse: got %b expected 0", run_done2); else n_pass++;
        n_total++; if (result !== 8'd76) $display("FAIL e5_result_held: got %0d expected 76", result); else n_pass++;
    endtask

    task automatic test_exponents();
        do_run(8'd0);
        n_total++; if (run_res !== 8'd1 || !run_ok) $display("FAIL e0_result: got %0d expected 1", run_res); else n_pass++;
        n_total++; if (run_starts !== 9) $display("FAIL e0_starts: got %0d expected 9", run_starts); else n_pass++;
        do_run(8'd1);
        n_total++; if (run_res !== 8'd7 || !run_ok) $display("FAIL e1_result: got %0d expected 7", run_res); else n_pass++;
        n_total++; if (run_starts !== 10) $display("FAIL e1_starts: got %0d expected 10", run_starts); else n_pass++;
        do_run(8'hFF);
        // 7^255 mod 143: 10 mod 11 and 5 mod 13 combine to 109
        n_total++; if (run_res !== 8'd109 || !run_ok) $display("FAIL eff_result: got %0d expected 109", run_res); else n_pass++;
        n_total++; if (run_starts !== 17) $display("FAIL eff_starts: got %0d expected 17", run_starts); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int s0;
        int i;
        exp_in  = 8'd5;
        m_mont  = 8'd76;
        r_mod_n = 8'd113;
        @(negedge clk);
        start = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        exp_in  = 8'hFF;
        m_mont  = 8'd5;
        r_mod_n = 8'd9;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!mm_start && i < 50) begin
            @(negedge clk);
            i++;
        end
        inj_done = 1'b1;
        inj_p    = 8'hA5;
        @(negedge clk);
        inj_done = 1'b0;
        i = 0;
        while (!done && i < 3000) begin
            @(negedge clk);
            i++;
        end
        n_total++; if (done !== 1'b1) $display("FAIL busy_start_timeout: got done=%b expected 1", done); else n_pass++;
        n_total++; if (result !== 8'd76) $display("FAIL busy_start_result: got %0d expected 76", result); else n_pass++;
        n_total++; if (start_cnt - s0 !== 11) $display("FAIL busy_start_starts: got %0d expected 11", start_cnt - s0); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int s0;
        int s1;
        int i;
        int done_seen;
        int busy_seen;
        exp_in  = 8'd5;
        m_mont  = 8'd76;
        r_mod_n = 8'd113;
        @(negedge clk);
        start = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        start = 1'b0;
        // Seventh operation of E=5 is the first multiply
        i = 0;
        while ((start_cnt - s0) < 7 && i < 500) begin
            @(negedge clk);
            i++;
        end
        n_total++; if (start_cnt - s0 !== 7) $display("FAIL abort_reach_mul: got %0d starts expected 7", start_cnt - s0); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
        n_total++; if (mm_start !== 1'b0) $display("FAIL abort_mm_start: got %b expected 0", mm_start); else n_pass++;
        rst = 1'b0;
        s1 = start_cnt;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        n_total++; if (start_cnt - s1 !== 0) $display("FAIL abort_late_starts: got %0d expected 0", start_cnt - s1); else n_pass++;
        n_total++; if (done_seen + busy_seen !== 0) $display("FAIL abort_late_activity: got %0d expected 0", done_seen + busy_seen); else n_pass++;
        do_run(8'd5);
        n_total++; if (run_res !== 8'd76 || !run_ok) $display("FAIL abort_rerun: got %0d expected 76", run_res); else n_pass++;
    endtask

    task automatic test_random_latency();
        lat_rand = 1'b1;
        do_run(8'd5);
        n_total++; if (run_res !== 8'd76 || !run_ok) $display("FAIL rand_e5: got %0d expected 76", run_res); else n_pass++;
        do_run(8'hFF);
        n_total++; if (run_res !== 8'd109 || !run_ok) $display("FAIL rand_eff: got %0d expected 109", run_res); else n_pass++;
        do_run(8'd0);
        n_total++; if (run_res !== 8'd1 || !run_ok) $display("FAIL rand_e0: got %0d expected 1", run_res); else n_pass++;
        lat_rand = 1'b0;
        n_total++; if (stab_err !== 0) $display("FAIL operand_stability: got %0d changes expected 0", stab_err); else n_pass++;
        n_total++; if (overlap_err !== 0) $display("FAIL mm_start_overlap: got %0d expected 0", overlap_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int i;
        int held_err;
        do_run(8'd5);
        n_total++; if (run_res !== 8'd76 || !run_ok) $display("FAIL b2b_first: got %0d expected 76", run_res); else n_pass++;
        // do_run returns at the first IDLE cycle after done
        exp_in = 8'hFF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy); else n_pass++;
        held_err = 0;
        i = 0;
        while (!done && i < 3000) begin
            if (result !== 8'd76) held_err++;
            @(negedge clk);
            i++;
        end
        n_total++; if (held_err !== 0) $display("FAIL b2b_held: got %0d changes expected 0", held_err); else n_pass++;
        n_total++; if (result !== 8'd109 || !done) $display("FAIL b2b_second: got %0d expected 109", result); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        for (int unsigned k = 1; k < c_N; k++) begin
            if (((256 * k) % c_N) == 1) rinv = k;
        end
        test_reset();
        test_e5();
        test_exponents();
        test_start_while_busy();
        test_reset_abort();
        test_random_latency();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
